// File: rtl/knn_vote_if.sv
// Neighbour-entry and vote-result handshakes for knn_vote.
// The master side feeds neighbours and consumes the vote; the slave side is the voter.
interface knn_vote_if #(
    parameter int DATA_W     = 32,
    parameter int LABEL_BITS = 8,
    parameter int NBR_KNN    = 4
);
    localparam int CNT_W = $clog2(NBR_KNN + 1);

    logic                  nn_valid;
    logic                  nn_ready;
    logic [LABEL_BITS-1:0] nn_label;
    logic [DATA_W-1:0]     nn_dist;
    logic                  vote_valid;
    logic                  vote_ready;
    logic [LABEL_BITS-1:0] vote_label;
    logic [CNT_W-1:0]      vote_count;
    logic [1:0]            vote_err;

    modport master (
        output nn_valid, nn_label, nn_dist, vote_ready,
        input  nn_ready, vote_valid, vote_label, vote_count, vote_err
    );

    modport slave (
        input  nn_valid, nn_label, nn_dist, vote_ready,
        output nn_ready, vote_valid, vote_label, vote_count, vote_err
    );
endinterface

// File: rtl/knn_vote.sv
// k-nearest-neighbour majority vote: collects NBR_KNN ranked neighbours, tallies
// per-label votes, then scans labels to pick the winner (ties go to the nearest first vote).
module knn_lbl_lane #(
    parameter int CNT_W  = 3,
    parameter int RANK_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              hit,
    input  logic [RANK_W-1:0] rank,
    output logic [CNT_W-1:0]  cnt,
    output logic [RANK_W-1:0] first
);
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt   <= '0;
            first <= '0;
        end else if (hit) begin
            // first rank is only meaningful once cnt is nonzero
            if (cnt == '0) first <= rank;
            cnt <= cnt + 1'b1;
        end
    end
endmodule

module knn_vote #(
    parameter int DATA_W     = 32,
    parameter int LABEL_BITS = 8,
    parameter int NBR_LABELS = 4,
    parameter int NBR_KNN    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    knn_vote_if.slave  bus
);
    localparam int CNT_W  = $clog2(NBR_KNN + 1);
    localparam int RANK_W = (NBR_KNN > 1) ? $clog2(NBR_KNN) : 1;
    localparam int LBL_W  = (NBR_LABELS > 1) ? $clog2(NBR_LABELS) : 1;
    localparam int SCAN_W = $clog2(NBR_LABELS + 1);
    localparam logic [LABEL_BITS:0] NL_EXT = (LABEL_BITS + 1)'(NBR_LABELS);

    typedef enum logic [1:0] {IDLE, COLLECT, DECIDE, OUTPUT} state_t;
    state_t state, state_nxt;

    logic                  clr, accept, last_ent, in_range, scan_done, take;
    logic [CNT_W-1:0]      ent_cnt;
    logic [DATA_W-1:0]     prev_dist;
    logic [1:0]            err;
    logic [SCAN_W-1:0]     scan_idx;
    logic [LBL_W-1:0]      scan_lbl;
    logic [CNT_W-1:0]      scan_cnt;
    logic [RANK_W-1:0]     scan_first;
    logic [LABEL_BITS-1:0] best_label;
    logic [CNT_W-1:0]      best_cnt;
    logic [RANK_W-1:0]     best_first;

    logic [NBR_LABELS-1:0][CNT_W-1:0]  cnt_arr;
    logic [NBR_LABELS-1:0][RANK_W-1:0] first_arr;
    logic [NBR_LABELS-1:0]             hit;

    assign clr       = (state == IDLE) && start;
    assign accept    = bus.nn_valid && (state == COLLECT);
    assign in_range  = {1'b0, bus.nn_label} < NL_EXT;
    assign last_ent  = ent_cnt == CNT_W'(NBR_KNN - 1);
    assign scan_done = scan_idx == SCAN_W'(NBR_LABELS);
    assign scan_lbl  = scan_idx[LBL_W-1:0];

    for (genvar l = 0; l < NBR_LABELS; l++) begin : g_lane
        assign hit[l] = accept && in_range && (bus.nn_label == LABEL_BITS'(l));
        knn_lbl_lane #(.CNT_W(CNT_W), .RANK_W(RANK_W)) u_lane (
            .clk   (clk),
            .rst   (rst),
            .clr   (clr),
            .hit   (hit[l]),
            .rank  (ent_cnt[RANK_W-1:0]),
            .cnt   (cnt_arr[l]),
            .first (first_arr[l])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.nn_ready   = 1'b0;
        bus.vote_valid = 1'b0;
        busy           = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = COLLECT;
            end
            COLLECT: begin
                bus.nn_ready = 1'b1;
                if (bus.nn_valid && last_ent) state_nxt = DECIDE;
            end
            DECIDE:  if (scan_done) state_nxt = OUTPUT;
            OUTPUT: begin
                bus.vote_valid = 1'b1;
                if (bus.vote_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        scan_cnt   = cnt_arr[scan_lbl];
        scan_first = first_arr[scan_lbl];
        take = (scan_cnt > best_cnt) ||
               ((scan_cnt == best_cnt) && (scan_cnt != '0) && (scan_first < best_first));
    end

    // The scan spends one extra cycle with scan_idx == NBR_LABELS before OUTPUT.
    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            ent_cnt    <= '0;
            prev_dist  <= '0;
            err        <= '0;
            scan_idx   <= '0;
            best_label <= '0;
            best_cnt   <= '0;
            best_first <= '0;
        end else begin
            if (accept) begin
                ent_cnt   <= last_ent ? '0 : ent_cnt + 1'b1;
                prev_dist <= bus.nn_dist;
                if (!in_range) err[0] <= 1'b1;
                if (ent_cnt != '0 && bus.nn_dist < prev_dist) err[1] <= 1'b1;
            end
            if (state == DECIDE && !scan_done) begin
                scan_idx <= scan_idx + 1'b1;
                if (take) begin
                    best_label <= LABEL_BITS'(scan_lbl);
                    best_cnt   <= scan_cnt;
                    best_first <= scan_first;
                end
            end
        end
    end

    assign bus.vote_label = best_label;
    assign bus.vote_count = best_cnt;
    assign bus.vote_err   = err;
endmodule

// File: doc/knn_vote.md
KNN_VOTE -- requirements
Module: knn_vote

Interface
REQ-001 Parameter DATA_W, default 32: width of each neighbour distance.
REQ-002 Parameter LABEL_BITS, default 8: width of each neighbour label.
REQ-003 Parameter NBR_LABELS, default 4: number of valid classes; labels 0..NBR_LABELS-1.
REQ-004 Parameter NBR_KNN, default 4: number of neighbour entries consumed per vote.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  synchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse that begins a vote; honoured only in IDLE.
REQ-008 nn_valid  input  1  neighbour entry present on nn_label/nn_dist.
REQ-009 nn_ready  output  1  block accepts a neighbour entry this cycle.
REQ-010 nn_label  input  LABEL_BITS  label of the offered neighbour.
REQ-011 nn_dist  input  DATA_W  distance of the offered neighbour, unsigned.
REQ-012 vote_valid  output  1  result present on vote_label/vote_count/vote_err.
REQ-013 vote_ready  input  1  consumer takes the result.
REQ-014 vote_label  output  LABEL_BITS  winning label.
REQ-015 vote_count  output  $clog2(NBR_KNN+1)  votes held by the winning label.
REQ-016 vote_err  output  2  bit0 label out of range seen; bit1 distance order violation seen.
REQ-017 busy  output  1  high in every state except IDLE.

Function
REQ-018 The FSM SHALL have exactly these states: IDLE, COLLECT, DECIDE, OUTPUT.
REQ-019 IDLE: with start=1, all per-label counters, first-rank registers, entry counter, previous distance and error flags clear; next state COLLECT.
REQ-020 COLLECT: nn_ready=1; an entry is accepted when nn_valid && nn_ready on a rising edge.
REQ-021 Entries arrive nearest first; the accepted entry index 0..NBR_KNN-1 is its rank.
REQ-022 Accepted label < NBR_LABELS: the label counter increments; the first-rank register for that label records the current rank only if this is the label's first vote.
REQ-023 Accepted label >= NBR_LABELS: no counter changes; sticky vote_err[0] sets; the entry still counts toward NBR_KNN.
REQ-024 Accepted entry at rank > 0 with nn_dist strictly less than the previous accepted nn_dist: sticky vote_err[1] sets; equal distances are legal.
REQ-025 After NBR_KNN accepts, nn_ready falls the next cycle and the state becomes DECIDE.
REQ-026 DECIDE: labels 0..NBR_LABELS-1 are scanned in order, one per cycle, NBR_LABELS cycles total.
REQ-027 A scanned label replaces the running best when its count is higher, or its count is equal, nonzero and its first rank is smaller.
REQ-028 The running best initialises to label 0, count 0; if every entry was out of range the result is label 0, count 0.
REQ-029 Latency: last accept at edge t gives vote_valid=1 after edge t+1+NBR_LABELS.
REQ-030 OUTPUT: vote_valid=1; vote_label, vote_count and vote_err stay stable until vote_valid && vote_ready; then the next state is IDLE and vote_valid=0.
REQ-031 start in COLLECT, DECIDE or OUTPUT SHALL be ignored.
REQ-032 nn_ready=0 in IDLE, DECIDE and OUTPUT; nn_valid there has no effect.
REQ-033 vote_ready outside OUTPUT SHALL have no effect.
REQ-034 Counters SHALL be wide enough that NBR_KNN votes for one label never wrap.

Reset
REQ-035 rst=0 on any edge, in any state, returns the FSM to IDLE and clears all counters, flags and registers.
REQ-036 During and after reset: nn_ready=0, vote_valid=0, vote_label=0, vote_count=0, vote_err=0, busy=0.
REQ-037 A vote interrupted by reset SHALL leave no residue in the next vote.

Verification (NBR_KNN=4, NBR_LABELS=4)
REQ-038 Labels 2,1,2,3 with distances 5,7,9,12 -> vote_label=2, vote_count=2, vote_err=00, vote_valid 5 cycles after the last accept.
REQ-039 Tie, labels 3,1,1,3 with distances 1,2,3,4 -> vote_label=3 (nearest first rank), vote_count=2.
REQ-040 Labels 7,1,0,1 -> vote_label=1, vote_count=2, vote_err=01.
REQ-041 Labels 0,0,1,2 with distances 10,4,6,8 -> vote_label=0, vote_count=2, vote_err=10.
REQ-042 vote_ready held low 5 cycles in OUTPUT -> outputs stable and nn_ready=0 throughout; start pulsed in that window ignored.
REQ-043 rst=0 after 2 accepts in COLLECT -> all outputs 0; a following start with labels 1,1,1,0 -> vote_label=1, vote_count=3, vote_err=00.
